// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared definitions for the systolic wavefront controller:
//                the controller state encoding and the PE diagonal-id helper.
//  Ports       : none (package)
//  Options     : SYSTOLIC_ABORT_EN (consumed by interface and top, not here)
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Diagonal id of PE(m,n): every PE on the same anti-diagonal sees the
  // wavefront on the same cycle.
  function automatic int diag_id(input int m, input int n);
    return m + n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_wave_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_wave_ctrl_if
//  Description : Job request / PE-control bundle of the wavefront controller.
//  Ports       : start, k_len, [abort]    - job request side (master drives)
//                op, first, busy, done    - controller outputs (slave drives)
//  Options     : SYSTOLIC_ABORT_EN adds the abort signal to both modports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface systolic_wave_ctrl_if #(
  parameter int ROWS  = 2,
  parameter int COLS  = 4,
  parameter int LEN_W = 4
);

  logic                   start;
  logic [LEN_W-1:0]       k_len;
`ifdef SYSTOLIC_ABORT_EN
  logic                   abort;
`endif
  logic [ROWS*COLS-1:0]   op;
  logic [ROWS*COLS-1:0]   first;
  logic                   busy;
  logic                   done;

`ifdef SYSTOLIC_ABORT_EN
  modport master (output start, k_len, abort, input  op, first, busy, done);
  modport slave  (input  start, k_len, abort, output op, first, busy, done);
`else
  modport master (output start, k_len, input  op, first, busy, done);
  modport slave  (input  start, k_len, output op, first, busy, done);
`endif

endinterface
`default_nettype wire

// File: rtl/systolic_pe_window.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pe_window
//  Description : Per-PE activity window. A PE on diagonal DIAG computes while
//                DIAG <= t <= DIAG+len-1 and clears its accumulator at t==DIAG.
//  Ports       : en_i    - controller is (about to be) in RUN
//                t_i     - RUN cycle index
//                len_i   - accumulation length L of the current job
//                op_o    - compute enable for this PE
//                first_o - accumulator-clear strobe for this PE
//  Options     : none
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_pe_window
  import systolic_pkg::*;
#(
  parameter int T_W   = 4,
  parameter int LEN_W = 4,
  parameter int DIAG  = 0
) (
  input  wire logic             en_i,
  input  wire logic [T_W-1:0]   t_i,
  input  wire logic [LEN_W-1:0] len_i,
  output logic                  op_o,
  output logic                  first_o
);

  // One spare bit so DIAG+len never wraps in the upper-bound compare.
  localparam int CW = T_W + LEN_W + 1;

  logic [CW-1:0] w_t;
  logic [CW-1:0] w_lo;
  logic [CW-1:0] w_hi;

  assign w_t  = CW'(t_i);
  assign w_lo = CW'(DIAG);
  assign w_hi = CW'(DIAG) + CW'(len_i);

  assign op_o    = en_i && (w_t >= w_lo) && (w_t < w_hi);
  assign first_o = en_i && (w_t == w_lo);

endmodule
`default_nettype wire

// File: rtl/systolic_wave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_wave_ctrl
//  Description : Skewed-wavefront controller for a ROWS x COLS systolic array.
//                A job of length L runs ROWS+COLS-2+L cycles; PE(m,n) is
//                enabled for L cycles starting at t = m+n.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active low
//                bus  - systolic_wave_ctrl_if.slave
//                       in : start, k_len, [abort]
//                       out: op, first (bit m*COLS+n -> PE(m,n)), busy, done
//  Options     : SYSTOLIC_ABORT_EN - enables abort of a running job.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_wave_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS  = 2,
  parameter int COLS  = 4,
  parameter int KMAX  = 8,
  parameter int LEN_W = $clog2(KMAX + 1)
) (
  input  wire logic            clk,
  input  wire logic            rst,
  systolic_wave_ctrl_if.slave  bus
);

  localparam int NPE = ROWS * COLS;
  // Holds the largest RUN index (ROWS+COLS-3+KMAX) and its successor.
  localparam int T_W = $clog2(ROWS + COLS - 2 + KMAX + 1);
  localparam logic [T_W:0] c_span = (T_W+1)'(ROWS + COLS - 2);

  state_e           state_q, state_d;
  logic [T_W-1:0]   t_q,     t_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [NPE-1:0]   op_q,    first_q;
  logic             busy_q,  done_q;

  logic [NPE-1:0]   w_op;
  logic [NPE-1:0]   w_first;
  logic             w_len_ok;
  logic             w_last;

  assign w_len_ok = (bus.k_len != '0) && (32'(bus.k_len) <= 32'(KMAX));
  // Last RUN cycle when t+1 == ROWS+COLS-2+L.
  assign w_last   = (({1'b0, t_q} + (T_W+1)'(1)) == (c_span + (T_W+1)'(len_q)));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (w_len_ok) begin
            state_d = RUN;
            t_d     = '0;
            len_d   = bus.k_len;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
`ifdef SYSTOLIC_ABORT_EN
        if (bus.abort) begin
          state_d = DONE;
        end else if (w_last) begin
          state_d = DONE;
        end else begin
          t_d = t_q + T_W'(1);
        end
`else
        if (w_last) begin
          state_d = DONE;
        end else begin
          t_d = t_q + T_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // PE windows evaluate the next-cycle state so op/first can be registered
  // and still line up with busy and the RUN index.
  // --------------------------------------------------------------------------
  for (genvar m = 0; m < ROWS; m++) begin : g_row
    for (genvar n = 0; n < COLS; n++) begin : g_col
      systolic_pe_window #(
        .T_W   (T_W),
        .LEN_W (LEN_W),
        .DIAG  (diag_id(m, n))
      ) u_win (
        .en_i    (state_d == RUN),
        .t_i     (t_d),
        .len_i   (len_d),
        .op_o    (w_op[m*COLS+n]),
        .first_o (w_first[m*COLS+n])
      );
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      len_q   <= '0;
      op_q    <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
      op_q    <= w_op;
      first_q <= w_first;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.op    = op_q;
  assign bus.first = first_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_wave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_wave_ctrl
//  Description : Directed self-checking bench for systolic_wave_ctrl. DUT A is
//                a 2x4 grid, DUT B a 2x2 grid, both with KMAX=8.
//  Ports       : none
//  Options     : SYSTOLIC_ABORT_EN enables the abort steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_wave_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  systolic_wave_ctrl_if #(.ROWS(2), .COLS(4), .LEN_W(4)) ifa ();
  systolic_wave_ctrl_if #(.ROWS(2), .COLS(2), .LEN_W(4)) ifb ();

  systolic_wave_ctrl #(.ROWS(2), .COLS(4), .KMAX(8), .LEN_W(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  systolic_wave_ctrl #(.ROWS(2), .COLS(2), .KMAX(8), .LEN_W(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // 2x4, L=1: one anti-diagonal per cycle, bit m*4+n
  logic [7:0] e_a1 [5] = '{8'h01, 8'h12, 8'h24, 8'h48, 8'h80};
  // 2x2, L=3: bit m*2+n
  logic [3:0] e_bop [5] = '{4'h1, 4'h7, 4'hF, 4'hE, 4'h8};
  logic [3:0] e_bfi [5] = '{4'h1, 4'h6, 4'h8, 4'h0, 4'h0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] eop, input logic [7:0] efi,
                       input logic eb, input logic ed);
    chk({tag, ".op"},    32'(ifa.op),    32'(eop));
    chk({tag, ".first"}, 32'(ifa.first), 32'(efi));
    chk({tag, ".busy"},  32'(ifa.busy),  32'(eb));
    chk({tag, ".done"},  32'(ifa.done),  32'(ed));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] eop, input logic [3:0] efi,
                       input logic eb, input logic ed);
    chk({tag, ".op"},    32'(ifb.op),    32'(eop));
    chk({tag, ".first"}, 32'(ifb.first), 32'(efi));
    chk({tag, ".busy"},  32'(ifb.busy),  32'(eb));
    chk({tag, ".done"},  32'(ifb.done),  32'(ed));
  endtask

  initial begin
    rst       = 1'b0;
    ifa.start = 1'b0;
    ifa.k_len = '0;
    ifb.start = 1'b0;
    ifb.k_len = '0;
`ifdef SYSTOLIC_ABORT_EN
    ifa.abort = 1'b0;
    ifb.abort = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    chk_a("rst_a", 8'h00, 8'h00, 1'b0, 1'b0);
    chk_b("rst_b", 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_a("idle_a", 8'h00, 8'h00, 1'b0, 1'b0);

    // 2x4, k_len=1: five RUN cycles, then done pulse
    ifa.start = 1'b1;
    ifa.k_len = 4'd1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      chk_a($sformatf("j1_t%0d", c), e_a1[c], e_a1[c], 1'b1, 1'b0);
    end
    tick();
    chk_a("j1_done", 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    chk_a("j1_idle", 8'h00, 8'h00, 1'b0, 1'b0);

    // Illegal lengths go straight to DONE
    ifa.start = 1'b1;
    ifa.k_len = 4'd0;
    tick();
    ifa.start = 1'b0;
    chk_a("klen0_done", 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    chk_a("klen0_idle", 8'h00, 8'h00, 1'b0, 1'b0);
    ifa.start = 1'b1;
    ifa.k_len = 4'd9;
    tick();
    ifa.start = 1'b0;
    chk_a("klen9_done", 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    chk_a("klen9_idle", 8'h00, 8'h00, 1'b0, 1'b0);

    // start held high, k_len=2: RUN x6, DONE, IDLE, RUN x6, DONE
    ifa.start = 1'b1;
    ifa.k_len = 4'd2;
    for (int c = 0; c < 16; c++) begin
      tick();
      chk($sformatf("b2b_c%0d.busy", c), 32'(ifa.busy),
          32'((c < 6) || (c >= 8 && c < 14)));
      chk($sformatf("b2b_c%0d.done", c), 32'(ifa.done), 32'(c == 6 || c == 14));
      if (c == 4)  chk_a("b2b_j1_t4", 8'hC8, 8'h80, 1'b1, 1'b0);
      if (c == 5)  chk_a("b2b_j1_t5", 8'h80, 8'h00, 1'b1, 1'b0);
      if (c == 12) chk_a("b2b_j2_t4", 8'hC8, 8'h80, 1'b1, 1'b0);
      if (c == 2)  ifa.k_len = 4'd5;
      if (c == 6)  ifa.k_len = 4'd2;
      if (c == 9)  ifa.start = 1'b0;
    end

    // 2x2, k_len=3
    ifb.start = 1'b1;
    ifb.k_len = 4'd3;
    tick();
    ifb.start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      chk_b($sformatf("b_t%0d", c), e_bop[c], e_bfi[c], 1'b1, 1'b0);
    end
    tick();
    chk_b("b_done", 4'h0, 4'h0, 1'b0, 1'b1);
    tick();
    chk_b("b_idle", 4'h0, 4'h0, 1'b0, 1'b0);

    // Reset in the middle of RUN: silent abort
    ifa.start = 1'b1;
    ifa.k_len = 4'd3;
    tick();
    ifa.start = 1'b0;
    tick();
    tick();
    chk_a("rstmid_t2", 8'h37, 8'h24, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    chk_a("rstmid_r", 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_a("rstmid_p1", 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    chk_a("rstmid_p2", 8'h00, 8'h00, 1'b0, 1'b0);

`ifdef SYSTOLIC_ABORT_EN
    // Abort at t=2 -> DONE next cycle
    ifa.start = 1'b1;
    ifa.k_len = 4'd3;
    tick();
    ifa.start = 1'b0;
    tick();
    tick();
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    chk_a("abort_done", 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    chk_a("abort_idle", 8'h00, 8'h00, 1'b0, 1'b0);
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    chk_a("abort_in_idle", 8'h00, 8'h00, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_wave_ctrl.md
SYSTOLIC_WAVE_CTRL -- requirements
Module: systolic_wave_ctrl

Interface
REQ-001 Parameter ROWS, default 2: PE grid rows, range 1..16.
REQ-002 Parameter COLS, default 4: PE grid columns, range 1..16.
REQ-003 Parameter KMAX, default 8: maximum accumulation length per job, >=1.
REQ-004 Parameter LEN_W, default $clog2(KMAX+1): width of k_len.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  job request; sampled only in IDLE.
REQ-008 k_len  in  LEN_W  operands per PE for this job; sampled with start.
REQ-009 abort  in  1  cancel running job (present only when SYSTOLIC_ABORT_EN is defined).
REQ-010 op  out  ROWS*COLS  PE compute enable; bit m*COLS+n drives PE(m,n).
REQ-011 first  out  ROWS*COLS  PE accumulator-clear strobe; same indexing as op.
REQ-012 busy  out  1  high while a job is in progress.
REQ-013 done  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: start=1 and 1<=k_len<=KMAX -> latch k_len as L, clear cycle counter t, go RUN.
REQ-016 IDLE: start=1 with k_len=0 or k_len>KMAX -> go DONE directly; no op asserted.
REQ-017 RUN cycle index t counts 0,1,2,... from the first cycle busy is high.
REQ-018 In RUN cycle t, op[PE(m,n)]=1 iff m+n <= t <= m+n+L-1 (skewed wavefront, diagonal id = m+n).
REQ-019 In RUN cycle t, first[PE(m,n)]=1 iff t == m+n; first implies op.
REQ-020 RUN lasts exactly ROWS+COLS-2+L cycles; after the last, go DONE.
REQ-021 DONE lasts one cycle: done=1, busy=0, op=0, first=0; then IDLE.
REQ-022 busy=1 exactly in RUN; start and k_len changes while not IDLE are ignored.
REQ-023 start asserted in the DONE cycle is ignored; a new job needs start in IDLE.
REQ-024 Counter t width sized to hold ROWS+COLS-2+KMAX without wrap; no wrap-around permitted.
REQ-025 Outside RUN, op and first are all-zero.

Reset
REQ-026 rst=0 at a clock edge -> state IDLE, t=0, L=0, op=0, first=0, busy=0, done=0.
REQ-027 Reset mid-RUN or in DONE aborts silently: no done pulse is produced.

Configuration
REQ-028 Macro SYSTOLIC_ABORT_EN defined: abort port exists; abort=1 in RUN -> next cycle state DONE with done=1, op=0, first=0.
REQ-029 abort=1 in IDLE or DONE has no effect; abort outranks end-of-RUN transition in the same cycle.
REQ-030 Macro undefined: no abort port; job always runs to completion.

Structure
REQ-031 Shared package systolic_pkg holds the state enum (IDLE, RUN, DONE) and a diag-id function returning m+n.
REQ-032 One sub-module systolic_pe_window: per-PE comparator producing op/first bits from t, L and the PE's diagonal id; instantiated ROWS*COLS times via generate.

Verification
REQ-033 ROWS=2,COLS=4,k_len=1, start in IDLE -> RUN 5 cycles; op(0,0) at t=0, op(0,3) and op(1,2) at t=3, op(1,3) at t=4; done pulse at cycle after t=4.
REQ-034 ROWS=2,COLS=2,k_len=3 -> op(0,0) at t=0..2, op(1,1) at t=2..4, first(1,1) only at t=2; busy 5 cycles.
REQ-035 k_len=0 with start -> next cycle done=1, busy never 1, op never nonzero.
REQ-036 start held high continuously with k_len=2 -> back-to-back jobs separated by exactly one DONE and one IDLE cycle; mid-run k_len change to 5 has no effect.
REQ-037 rst=0 at RUN t=2 -> next cycle all outputs zero, no done pulse; SYSTOLIC_ABORT_EN build: abort at t=2 -> done=1 next cycle, op=0.
